// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the set/reset command sequencer.
package sr_cmd_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      HOLD
   } state_t;

   // Combined rise vector: bit 0 = set, bit 1 = clear
   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_SET,
      CMD_CLR,
      CMD_BOTH
   } cmd_t;

endpackage

// File: rtl/sr_debounce.sv
// One request channel: two-flop synchronizer, debounce counter and
// rising-edge detector on the debounced level.
module sr_debounce
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic RST,
   input  logic raw_in,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             db;
   logic             db_d;
   logic [CNT_W-1:0] cnt;

   // Bring the raw request into the clk domain
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= raw_in;
         s2 <= s1;
      end
   end

   // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         cnt <= '0;
         db  <= 1'b0;
      end else if (s2 == db) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         db  <= s2;
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Delayed copy of the debounced level for edge detection
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         db_d <= 1'b0;
      end else begin
         db_d <= db;
      end
   end

   assign level = db;
   assign rise  = db & ~db_d;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns debounced set/clear request edges into mutually exclusive one-cycle
// S/R commands, flags simultaneous requests and drops requests that arrive
// while a command or hold-off window is in progress.
module sr_cmd_sequencer
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned HOLDOFF         = 8
) (
   input  logic clk,
   input  logic RST,
   input  logic set_raw,
   input  logic clr_raw,
   output logic S,
   output logic R,
   output logic conflict,
   output logic drop,
   output logic busy
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

   logic             set_lvl;
   logic             set_rise;
   logic             clr_lvl;
   logic             clr_rise;
   cmd_t             cmd;
   state_t           state;
   logic [CNT_W-1:0] hcnt;

   sr_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_set (
      .clk   (clk),
      .RST   (RST),
      .raw_in(set_raw),
      .level (set_lvl),
      .rise  (set_rise)
   );

   sr_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_clr (
      .clk   (clk),
      .RST   (RST),
      .raw_in(clr_raw),
      .level (clr_lvl),
      .rise  (clr_rise)
   );

   // Classify this cycle's settled rising edges
   always_comb begin
      cmd = CMD_NONE;
      unique case ({clr_rise & clr_lvl, set_rise & set_lvl})
         2'b01:   cmd = CMD_SET;
         2'b10:   cmd = CMD_CLR;
         2'b11:   cmd = CMD_BOTH;
         default: cmd = CMD_NONE;
      endcase
   end

   // Command FSM with hold-off counter; all outputs registered
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         hcnt     <= '0;
         S        <= 1'b0;
         R        <= 1'b0;
         conflict <= 1'b0;
         drop     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         S        <= 1'b0;
         R        <= 1'b0;
         conflict <= 1'b0;
         drop     <= 1'b0;
         unique case (state)
            IDLE: begin
               unique case (cmd)
                  CMD_SET: begin
                     S     <= 1'b1;
                     state <= EMIT;
                     busy  <= 1'b1;
                  end
                  CMD_CLR: begin
                     R     <= 1'b1;
                     state <= EMIT;
                     busy  <= 1'b1;
                  end
                  CMD_BOTH: begin
                     conflict <= 1'b1;
                     if (HOLDOFF > 0) begin
                        state <= HOLD;
                        hcnt  <= HOLD_LOAD;
                        busy  <= 1'b1;
                     end else begin
                        busy  <= 1'b0;
                     end
                  end
                  default: busy <= 1'b0;
               endcase
            end
            EMIT: begin
               drop <= (cmd != CMD_NONE);
               if (HOLDOFF > 0) begin
                  state <= HOLD;
                  hcnt  <= HOLD_LOAD;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            HOLD: begin
               drop <= (cmd != CMD_NONE);
               if (hcnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  hcnt  <= hcnt - CNT_W'(1);
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer with DEBOUNCE_CYCLES=4, HOLDOFF=8.
`timescale 1ns/1ps
module tb_sr_cmd_sequencer;

   logic clk = 1'b0;
   logic RST;
   logic set_raw;
   logic clr_raw;
   logic S;
   logic R;
   logic conflict;
   logic drop;
   logic busy;

   int tests = 0;
   int fails = 0;

   // per-window observations
   int s_cnt, s_first, r_cnt, r_first, c_cnt, c_first;
   int d_cnt, d_first, b_cnt, b_first, both_cnt;

   sr_cmd_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .HOLDOFF        (8)
   ) dut (
      .clk     (clk),
      .RST     (RST),
      .set_raw (set_raw),
      .clr_raw (clr_raw),
      .S       (S),
      .R       (R),
      .conflict(conflict),
      .drop    (drop),
      .busy    (busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish within 1ms");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Run n cycles; raise set/clr just before edge set_on/clr_on (-1 = never).
   // Index k is the sample taken 1 ns after edge k.
   task automatic window(input int n, input int set_on, input int clr_on);
      s_cnt = 0; r_cnt = 0; c_cnt = 0; d_cnt = 0; b_cnt = 0; both_cnt = 0;
      s_first = -1; r_first = -1; c_first = -1; d_first = -1; b_first = -1;
      for (int k = 0; k < n; k++) begin
         if (k == set_on) set_raw = 1'b1;
         if (k == clr_on) clr_raw = 1'b1;
         tick();
         if (S)        begin s_cnt++; if (s_first < 0) s_first = k; end
         if (R)        begin r_cnt++; if (r_first < 0) r_first = k; end
         if (conflict) begin c_cnt++; if (c_first < 0) c_first = k; end
         if (drop)     begin d_cnt++; if (d_first < 0) d_first = k; end
         if (busy)     begin b_cnt++; if (b_first < 0) b_first = k; end
         if (S && R)   both_cnt++;
      end
   endtask

   task automatic settle_low();
      set_raw = 1'b0;
      clr_raw = 1'b0;
      repeat (20) tick();
   endtask

   initial begin
      int bounce_s;
      int bad_both, bad_sw, bad_rw, bad_busy, s_pulses;
      logic prev_s, prev_r;

      // ---- reset state
      RST = 1'b1; set_raw = 1'b0; clr_raw = 1'b0;
      repeat (3) tick();
      chk("reset_S", int'(S), 0);
      chk("reset_R", int'(R), 0);
      chk("reset_conflict", int'(conflict), 0);
      chk("reset_drop", int'(drop), 0);
      chk("reset_busy", int'(busy), 0);
      RST = 1'b0;
      repeat (5) tick();

      // ---- clean set
      window(30, 0, -1);
      chk("clean_s_cnt", s_cnt, 1);
      chk("clean_s_first", s_first, 6);
      chk("clean_r_cnt", r_cnt, 0);
      chk("clean_busy_cnt", b_cnt, 9);
      chk("clean_busy_first", b_first, 6);
      chk("clean_conflict", c_cnt, 0);
      chk("clean_drop", d_cnt, 0);
      settle_low();

      // ---- bounce 1,0,1,0 then stable 1
      bounce_s = 0;
      set_raw = 1'b1; tick(); if (S) bounce_s++;
      set_raw = 1'b0; tick(); if (S) bounce_s++;
      set_raw = 1'b1; tick(); if (S) bounce_s++;
      set_raw = 1'b0; tick(); if (S) bounce_s++;
      window(30, 0, -1);
      chk("bounce_no_early_s", bounce_s, 0);
      chk("bounce_s_cnt", s_cnt, 1);
      chk("bounce_s_first", s_first, 6);
      settle_low();

      // ---- simultaneous requests
      window(30, 0, 0);
      chk("simul_conflict_cnt", c_cnt, 1);
      chk("simul_conflict_first", c_first, 6);
      chk("simul_s_cnt", s_cnt, 0);
      chk("simul_r_cnt", r_cnt, 0);
      chk("simul_busy_cnt", b_cnt, 8);
      chk("simul_busy_first", b_first, 6);
      settle_low();

      // ---- hold-off drop: R at edge 6, set rise evaluated at edge 9
      window(30, 3, 0);
      chk("drop_r_cnt", r_cnt, 1);
      chk("drop_r_first", r_first, 6);
      chk("drop_s_cnt", s_cnt, 0);
      chk("drop_cnt", d_cnt, 1);
      chk("drop_first", d_first, 9);
      chk("drop_busy_cnt", b_cnt, 9);
      chk("drop_sr_both", both_cnt, 0);
      settle_low();

      // ---- reset mid-hold with set held high through release
      set_raw = 1'b1;
      repeat (7) tick();
      chk("rst_pre_S", int'(S), 1);
      repeat (2) tick();
      chk("rst_pre_busy", int'(busy), 1);
      #3 RST = 1'b1;
      #1;
      chk("rst_async_busy", int'(busy), 0);
      chk("rst_async_S", int'(S), 0);
      chk("rst_async_R", int'(R), 0);
      chk("rst_async_conflict", int'(conflict), 0);
      chk("rst_async_drop", int'(drop), 0);
      repeat (2) tick();
      RST = 1'b0;
      window(20, -1, -1);
      chk("rst_release_s_cnt", s_cnt, 1);
      chk("rst_release_s_first", s_first, 6);
      chk("rst_release_busy_cnt", b_cnt, 9);
      settle_low();

      // ---- random stimulus invariant
      bad_both = 0; bad_sw = 0; bad_rw = 0; bad_busy = 0; s_pulses = 0;
      prev_s = 1'b0; prev_r = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(15) == 0) set_raw = ~set_raw;
         if ($urandom_range(15) == 0) clr_raw = ~clr_raw;
         tick();
         if (S && R) bad_both++;
         if (S && prev_s) bad_sw++;
         if (R && prev_r) bad_rw++;
         if ((S || R) && !busy) bad_busy++;
         if (S && !prev_s) s_pulses++;
         prev_s = S;
         prev_r = R;
      end
      chk("rand_s_and_r", bad_both, 0);
      chk("rand_s_width", bad_sw, 0);
      chk("rand_r_width", bad_rw, 0);
      chk("rand_cmd_not_busy", bad_busy, 0);
      chk("rand_some_s_pulses", int'(s_pulses > 0), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sr_cmd_sequencer.md
# sr_cmd_sequencer

Upstream command stage for the set/reset flip-flop block. Takes two raw, asynchronous, bouncy request lines (set and clear), synchronizes and debounces each, converts settled rising edges into single-cycle S or R command pulses, and guarantees the downstream flip-flop never sees S and R high together. Simultaneous requests are flagged and suppressed. A post-command hold-off window drops further requests.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples required to accept a level change; legal range 1..255.
- HOLDOFF, 8: idle cycles enforced after every issued command or conflict; 0 disables hold-off; legal range 0..255.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- RST  in  1  reset, asynchronous, active-high; clears all state immediately.
- set_raw  in  1  raw set request, asynchronous to clk.
- clr_raw  in  1  raw clear request, asynchronous to clk.
- S  out  1  registered one-cycle set command to the flip-flop.
- R  out  1  registered one-cycle clear command to the flip-flop.
- conflict  out  1  registered one-cycle pulse: both requests settled high in the same cycle.
- drop  out  1  registered one-cycle pulse: a request was ignored during EMIT/HOLD.
- busy  out  1  high whenever the FSM is not IDLE.

## Operation
- Per channel: two-flop synchronizer (s1, s2), then debounce counter cnt (8 bits) with debounced level db.
  - s2 == db: cnt <= 0.
  - s2 != db and cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - Any bounce back to db before acceptance restarts the count.
- Rise event = db & ~db_d, where db_d is db delayed one cycle. Falling edges generate no event.
- FSM states IDLE, EMIT, HOLD:
  - IDLE, exactly one rise: go to EMIT. Drive S (set) or R (clear) high for that one EMIT cycle.
  - IDLE, both rises: conflict <= 1 for one cycle. S and R stay 0. Go to HOLD, or to IDLE if HOLDOFF == 0.
  - EMIT: go to HOLD if HOLDOFF > 0, else go to IDLE.
  - HOLD: counts HOLDOFF cycles, then goes to IDLE.
  - Any rise in EMIT or HOLD: drop <= 1 for one cycle. The event is discarded, not queued.
- Invariant: S & R == 0 in every cycle. S or R high implies the FSM is in EMIT.
- Reset values: S=0, R=0, conflict=0, drop=0, busy=0. s1, s2 and db are 0; counters are 0; FSM is IDLE.
- Reset mid-operation aborts any pulse or hold-off immediately, with no trailing pulse.
- An input held high through reset release is treated as a new rise and is issued after the normal latency.

## Timing
- Take edge 0 as the first clk edge that captures the new raw level in s1. With a bounce-free input:
  - s2 updates at edge 1.
  - db updates at edge 1+DEBOUNCE_CYCLES.
  - S or R is high from edge 2+DEBOUNCE_CYCLES to edge 3+DEBOUNCE_CYCLES.
  - Total latency is DEBOUNCE_CYCLES+2 edges after capture.
- S and R pulse width: exactly 1 cycle.
- busy is high from the EMIT edge through the last HOLD cycle: 1+HOLDOFF cycles.
- Minimum spacing between two issued commands: 1+HOLDOFF cycles, plus debounce of the new edge.
- conflict and drop are registered on the same edge the FSM evaluates the rise events.

## Structure
- Shared package sr_cmd_pkg:
  - state_t enum {IDLE, EMIT, HOLD}.
  - cmd_t enum {CMD_NONE, CMD_SET, CMD_CLR, CMD_BOTH} for the combined rise vector.
  - Localparam CNT_W = 8.
- Sub-module sr_debounce, instantiated twice: synchronizer, counter, db, db_d and rise output. Parameter DEBOUNCE_CYCLES; ports clk, RST, raw_in, level, rise.
- Top level holds the FSM, the hold-off counter and the output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLDOFF=8.
- Clean set: set_raw goes 0→1 before edge 0 and stays high. Required: S=1 for exactly one cycle after edge 6, R=0 throughout, busy high for 9 cycles.
- Bounce: set_raw toggles 1,0,1,0 on successive cycles, then stays 1. Required: exactly one S pulse, 6 edges after the final stable capture edge. No pulse during the bounce.
- Simultaneous: set_raw and clr_raw rise in the same cycle. Required: conflict=1 for one cycle at edge 6, S=R=0 always, busy for 8 cycles.
- Hold-off drop: clr_raw rises, then set_raw rises so its debounced edge lands 3 cycles after R. Required: R pulse only, drop=1 for one cycle, and no S pulse afterwards until a new rise.
- Reset mid-hold: assert RST two cycles after an S pulse, asynchronously between edges. Required: busy, S, R, conflict and drop go 0 immediately. With set_raw still high at release, S pulses again 6 edges after release.
- Invariant: random raw stimulus for 10k cycles. Required: S&R never 1, and every S/R pulse is exactly one cycle wide.
